// File: rtl/bootrom_port_ctrl.sv
// Port-B controller for the boot instruction RAM: assembles loader bytes into
// little-endian words and shares the single port with core data-side reads.
module bootrom_port_ctrl #(
  parameter int RAM_DEPTH = 65536,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_rvalid,
  output logic [31:0]       rd_rdata,
  output logic              mem_enb,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addrb,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_doutb
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_WRQ  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [31:0]       word_q, word_d;
  logic              rr_q, rr_d;
  logic              done_q, done_d;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] addrb_q, addrb_d;
  logic [31:0]       din_q, din_d;
  logic              wr_pend_s, rd_win_s, wr_win_s;

  assign wr_pend_s = (state_q == ST_WRQ);

  // Single-op-per-cycle arbiter; rr_q set means the write owns the next contest.
  always_comb begin
    rd_win_s = 1'b0;
    wr_win_s = 1'b0;
    rr_d     = rr_q;
    if (rd_req && wr_pend_s) begin
      if (rr_q) begin
        wr_win_s = 1'b1;
      end else begin
        rd_win_s = 1'b1;
      end
      rr_d = ~rr_q;
    end else if (rd_req) begin
      rd_win_s = 1'b1;
    end else if (wr_pend_s) begin
      wr_win_s = 1'b1;
    end else begin
      rr_d = rr_q;
    end
  end

  // Load session sequencing and byte-lane assembly.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_addr_d   = wr_addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = 2'd0;
        if (ld_start) begin
          wr_addr_d   = ld_base;
          remaining_d = ld_len;
          if (ld_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (ld_valid) begin
          word_d[{idx_q, 3'b000} +: 8] = ld_byte;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_WRQ;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_WRQ: begin
        if (wr_win_s) begin
          wr_addr_d   = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (remaining_q == (ADDR_W+1)'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_WRQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Port-B address/data hold their last driven value on idle cycles.
  always_comb begin
    addrb_d = addrb_q;
    din_d   = din_q;
    if (rd_win_s) begin
      addrb_d = rd_addr;
    end else if (wr_win_s) begin
      addrb_d = wr_addr_q;
      din_d   = word_q;
    end else begin
      addrb_d = addrb_q;
    end
  end

  assign ld_ready  = (state_q == ST_FILL);
  assign ld_busy   = (state_q != ST_IDLE);
  assign ld_done   = done_q;
  assign rd_gnt    = rd_win_s;
  assign mem_enb   = rd_win_s;
  assign mem_wen   = wr_win_s;
  assign mem_addrb = addrb_d;
  assign mem_din   = din_d;
  assign rd_rvalid = rvalid_q;
  assign rd_rdata  = rvalid_q ? mem_doutb : rdata_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      wr_addr_q   <= '0;
      remaining_q <= '0;
      word_q      <= 32'd0;
      rr_q        <= 1'b0;
      done_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
      addrb_q     <= '0;
      din_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_addr_q   <= wr_addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      rr_q        <= rr_d;
      done_q      <= done_d;
      rvalid_q    <= rd_win_s;
      rdata_q     <= rd_rdata;
      addrb_q     <= addrb_d;
      din_q       <= din_d;
    end
  end

endmodule

// File: doc/bootrom_port_ctrl.md
Name: bootrom_port_ctrl

Overview:
Controller for the write/read port (port B) of the dual-port boot instruction memory. Shares that single port between the core's data-side read requester and a byte-stream program loader (UART/JTAG downloader). Assembles loader bytes into 32-bit little-endian words and writes them at auto-incrementing word addresses. Arbitrates write slots against core reads without starving either requester. Port A (instruction fetch) is untouched.

Parameters:
RAM_DEPTH, 65536, memory depth in 32-bit words; must be a power of two.
ADDR_W, 16, word-address width; must equal log2(RAM_DEPTH).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ld_start  in  1  one-cycle pulse: begin a load session
ld_base  in  ADDR_W  first word address, sampled on ld_start
ld_len  in  ADDR_W+1  number of words to write, sampled on ld_start
ld_valid  in  1  loader byte valid
ld_byte  in  8  loader byte
ld_ready  out  1  controller accepts ld_byte this cycle
ld_busy  out  1  session active
ld_done  out  1  one-cycle pulse: session complete
rd_req  in  1  core read request, held until granted
rd_addr  in  ADDR_W  core read word address
rd_gnt  out  1  read issued to memory this cycle
rd_rvalid  out  1  read data valid (cycle after rd_gnt)
rd_rdata  out  32  read data
mem_enb  out  1  memory port-B read enable
mem_wen  out  1  memory write enable
mem_addrb  out  ADDR_W  memory port-B address (shared by read and write)
mem_din  out  32  memory write data
mem_doutb  in  32  memory port-B read data (1-cycle registered)

Behaviour:
- Reset: every output 0; FSM IDLE; byte index, address, word counter, RR-priority flag cleared. Async assert aborts any session immediately; partial word discarded; no ld_done.
- FSM IDLE: ld_busy=0, ld_ready=0. ld_start -> latch ld_base to wr_addr, ld_len to remaining. If ld_len==0: pulse ld_done next cycle, stay IDLE. Else -> FILL.
- FILL: ld_busy=1, ld_ready=1. Each ld_valid&ld_ready stores byte at lane idx (idx 0 -> bits 7:0 ... idx 3 -> bits 31:24), idx++. Fourth byte -> WRQ, idx=0.
- WRQ: ld_ready=0; write pending. When write wins arbitration: mem_wen=1, mem_enb=0, mem_addrb=wr_addr, mem_din=word for that one cycle. Then wr_addr+1 (wraps RAM_DEPTH-1 -> 0), remaining-1. If remaining becomes 0: ld_done=1 the following cycle, -> IDLE; else -> FILL.
- ld_start while ld_busy=1 ignored.
- Arbitration (combinational grant, one op per cycle): only read pending -> read; only write pending -> write; both -> alternate via RR flag (flag toggles on each contested grant; after reset a contest goes to read first).
- mem_wen and mem_enb never high together. Idle cycles: mem_enb=0, mem_wen=0; mem_addrb/mem_din hold last value.
- Read: rd_gnt=1 and mem_enb=1 with mem_addrb=rd_addr in cycle N; rd_rvalid=1, rd_rdata=mem_doutb in cycle N+1 (rd_rdata driven from mem_doutb). Back-to-back grants -> rvalid every cycle. rd_rdata holds when rd_rvalid=0.
- Read of an address written in the same session returns new data only if read granted at least one cycle after the write cycle (memory is read-first).
- Max write latency in WRQ under continuous rd_req: 2 cycles.

Test Plan:
- Reset: rst_n low mid-FILL after 2 bytes -> all outputs 0; new ld_start base=0x10 len=1, bytes 11 22 33 44 -> single write addr 0x10 data 0x44332211, ld_done one cycle later.
- Load base=0x0000 len=3, 12 bytes streamed every cycle, no reads -> writes to 0,1,2 with correct little-endian words; ld_ready low 1 cycle per WRQ; exactly one ld_done.
- Wrap: base=RAM_DEPTH-1 len=2 -> writes at 0xFFFF then 0x0000.
- len=0 -> ld_done pulses once, no mem_wen, ld_busy stays 0.
- Contention: rd_req held continuously with addrs 5,6,7... during a len=2 load -> writes and reads alternate when both pending, each write issued within 2 cycles of WRQ entry, no cycle with mem_wen&mem_enb, rd_rvalid exactly one cycle after each rd_gnt with matching data.
- Read-after-write: write 0xDEADBEEF to addr 8, then rd_addr=8 -> rd_rdata=0xDEADBEEF; ld_start during busy ignored (base/len unchanged).
